// File: rtl/time_oper_sched_pkg.sv
// Shared constants and types for the time-of-day sequencer.
// Opcodes, day length, FSM state encoding and grant-source type.
package time_pkg;

    localparam logic [2:0] OP_RESET = 3'd1;
    localparam logic [2:0] OP_DEC   = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd4;

    localparam int DAY_LEN = 86400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WRAP = 2'd2
    } state_e;

    typedef enum logic {
        SRC_TICK = 1'b0,
        SRC_OPER = 1'b1
    } grant_src_e;

endpackage

// File: rtl/time_oper_sched_if.sv
// Operation/tick/time bundle between the button driver, the sequencer and the display path.
// master drives operations and ticks; slave is the sequencer.
interface time_oper_sched_if #(
    parameter int time_buff_size = 18,
    parameter int oper_l         = 3
);
    logic [time_buff_size+oper_l-1:0] OPER;
    logic                             OPER_VALID;
    logic                             OPER_READY;
    logic                             TICK;
    logic [time_buff_size-1:0]        TIME;
    logic                             BUSY;
    logic                             DONE;
    logic                             ERR;
    logic                             TICK_LOST;

    modport master (
        output OPER, OPER_VALID, TICK,
        input  OPER_READY, TIME, BUSY, DONE, ERR, TICK_LOST
    );

    modport slave (
        input  OPER, OPER_VALID, TICK,
        output OPER_READY, TIME, BUSY, DONE, ERR, TICK_LOST
    );
endinterface

// File: rtl/time_oper_sched_fifo.sv
// Synchronous operation queue with push/pop, full/empty flags and async active-low reset.
// DEPTH must be a power of two, at least 2.
module oper_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/time_oper_sched.sv
// Time-of-day sequencer: queues operation words, arbitrates them against the 1 Hz tick
// and applies each as a two-step modulo-day update. TIME_SCHED_FIFO_EN selects the deep queue.
//
//   state | meaning
//   IDLE  | pick queue head or pending tick (alternate on conflict), latch it
//   EXEC  | form 19-bit raw result, flag illegal ops
//   WRAP  | fold raw back into 0..day_len-1, commit TIME, pulse DONE or ERR
module time_oper_sched
    import time_pkg::*;
#(
    parameter int time_buff_size = 18,
    parameter int oper_l         = 3,
    parameter int day_len        = DAY_LEN,
    parameter int fifo_depth     = 4
) (
    input logic               CLK,
    input logic               RST_N,
    time_oper_sched_if.slave  bus
);
    localparam int TW = time_buff_size;
    localparam int OW = time_buff_size + oper_l;
    localparam int RW = time_buff_size + 1;
    localparam logic [RW-1:0] DAY = RW'(day_len);

    logic [OW-1:0] head;
    logic          q_full, q_empty, push, pop;

    assign push           = bus.OPER_VALID && !q_full;
    assign bus.OPER_READY = !q_full;

`ifdef TIME_SCHED_FIFO_EN
    oper_fifo #(
        .WIDTH (OW),
        .DEPTH (fifo_depth)
    ) u_oper_fifo (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .push_i  (push),
        .din_i   (bus.OPER),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );
`else
    // Single holding register; ready is derived from its one-entry occupancy count.
    localparam int CW = $clog2(fifo_depth) + 1;
    logic [OW-1:0] hold_q;
    logic          hold_vld_q;
    logic [CW-1:0] q_cnt;

    assign q_cnt   = CW'(hold_vld_q);
    assign q_full  = (q_cnt == CW'(1));
    assign q_empty = (q_cnt == '0);
    assign head    = hold_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else if (push) begin
            hold_q     <= bus.OPER;
            hold_vld_q <= 1'b1;
        end else if (pop) begin
            hold_vld_q <= 1'b0;
        end
    end
`endif

    state_e            state_q, state_d;
    grant_src_e        last_q, last_d;
    logic [oper_l-1:0] code_q, code_d;
    logic [TW-1:0]     val_q, val_d;
    logic [RW-1:0]     raw_q, raw_d;
    logic              illegal_q, illegal_d;
    logic [TW-1:0]     time_q, time_d;
    logic [1:0]        tcnt_q, tcnt_d;
    logic              done_q, done_d, err_q, err_d, lost_q, lost_d;
    logic              grant_op, grant_tick, val_oor;

    always_comb begin
        grant_op   = 1'b0;
        grant_tick = 1'b0;
        if (state_q == IDLE) begin
            if (!q_empty && tcnt_q != 2'd0) begin
                if (last_q == SRC_OPER) grant_tick = 1'b1;
                else                    grant_op   = 1'b1;
            end else if (!q_empty) begin
                grant_op = 1'b1;
            end else if (tcnt_q != 2'd0) begin
                grant_tick = 1'b1;
            end
        end
    end

    assign pop     = grant_op;
    assign val_oor = ({1'b0, val_q} >= DAY);

    // A tick that arrives while its predecessor is being granted just replaces it.
    always_comb begin
        tcnt_d = tcnt_q;
        lost_d = 1'b0;
        if (bus.TICK && !grant_tick) begin
            if (tcnt_q == 2'd3) lost_d = 1'b1;
            else                tcnt_d = tcnt_q + 2'd1;
        end else if (!bus.TICK && grant_tick) begin
            tcnt_d = tcnt_q - 2'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        code_d    = code_q;
        val_d     = val_q;
        raw_d     = raw_q;
        illegal_d = illegal_q;
        time_d    = time_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_op) begin
                    code_d  = head[oper_l-1:0];
                    val_d   = head[OW-1:oper_l];
                    last_d  = SRC_OPER;
                    state_d = EXEC;
                end else if (grant_tick) begin
                    code_d  = oper_l'(OP_ADD);
                    val_d   = TW'(1);
                    last_d  = SRC_TICK;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                illegal_d = 1'b0;
                raw_d     = '0;
                case (code_q)
                    oper_l'(OP_RESET): raw_d = '0;
                    oper_l'(OP_ADD): begin
                        raw_d     = {1'b0, time_q} + {1'b0, val_q};
                        illegal_d = val_oor;
                    end
                    oper_l'(OP_DEC): begin
                        raw_d     = {1'b0, time_q} - {1'b0, val_q};
                        illegal_d = val_oor;
                    end
                    default: illegal_d = 1'b1;
                endcase
                state_d = WRAP;
            end
            WRAP: begin
                if (illegal_q) begin
                    err_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                    if (code_q == oper_l'(OP_ADD) && raw_q >= DAY)
                        time_d = TW'(raw_q - DAY);
                    else if (code_q == oper_l'(OP_DEC) && raw_q[RW-1])
                        time_d = TW'(raw_q + DAY);
                    else
                        time_d = raw_q[TW-1:0];
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            last_q    <= SRC_TICK;
            code_q    <= '0;
            val_q     <= '0;
            raw_q     <= '0;
            illegal_q <= 1'b0;
            time_q    <= '0;
            tcnt_q    <= 2'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            code_q    <= code_d;
            val_q     <= val_d;
            raw_q     <= raw_d;
            illegal_q <= illegal_d;
            time_q    <= time_d;
            tcnt_q    <= tcnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            lost_q    <= lost_d;
        end
    end

    assign bus.TIME      = time_q;
    assign bus.BUSY      = (state_q != IDLE);
    assign bus.DONE      = done_q;
    assign bus.ERR       = err_q;
    assign bus.TICK_LOST = lost_q;
endmodule

// File: tb/tb_time_oper_sched.sv
// Bench for time_oper_sched: directed scenarios plus random traffic against a
// queue-based reference model of the arbitration and modulo-day arithmetic.
module tb_time_oper_sched;
    import time_pkg::*;

    localparam int TW = 18;
    localparam int OL = 3;
    localparam int DL = 86400;
`ifdef TIME_SCHED_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic CLK = 1'b0;
    logic RST_N = 1'b0;

    time_oper_sched_if #(.time_buff_size(TW), .oper_l(OL)) bus ();

    time_oper_sched #(
        .time_buff_size (TW),
        .oper_l         (OL),
        .day_len        (DL),
        .fifo_depth     (4)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pending ops as a queue, ticks as an integer, and the
    // in-flight op as a countdown of the three cycles it occupies.
    typedef struct {
        int code;
        int val;
    } op_t;

    op_t mq[$];
    int  m_time, m_ticks, m_phase;
    bit  m_last_op;
    op_t m_cur;
    bit  m_done, m_err, m_lost;

    function automatic void model_reset();
        mq.delete();
        m_time    = 0;
        m_ticks   = 0;
        m_phase   = 0;
        m_last_op = 1'b0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_lost    = 1'b0;
    endfunction

    function automatic void model_apply();
        if (m_cur.code == 1) begin
            m_time = 0;
            m_done = 1'b1;
        end else if (m_cur.code == 4 && m_cur.val < DL) begin
            m_time = (m_time + m_cur.val) % DL;
            m_done = 1'b1;
        end else if (m_cur.code == 2 && m_cur.val < DL) begin
            m_time = (m_time - m_cur.val + DL) % DL;
            m_done = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_edge(input bit v, input int code, input int val, input bit t);
        bit g_op = 1'b0;
        bit g_tick = 1'b0;
        bit acc = v && (mq.size() < DEPTH);
        int nt;
        m_done = 1'b0;
        m_err  = 1'b0;
        m_lost = 1'b0;
        if (m_phase == 0) begin
            if (mq.size() > 0 && m_ticks > 0) begin
                if (m_last_op) g_tick = 1'b1;
                else           g_op   = 1'b1;
            end else if (mq.size() > 0) begin
                g_op = 1'b1;
            end else if (m_ticks > 0) begin
                g_tick = 1'b1;
            end
            if (g_op) begin
                m_cur = mq.pop_front();
                m_last_op = 1'b1;
                m_phase = 1;
            end else if (g_tick) begin
                m_cur = '{4, 1};
                m_last_op = 1'b0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            model_apply();
            m_phase = 0;
        end
        if (acc) mq.push_back('{code, val});
        nt = m_ticks - int'(g_tick) + int'(t);
        if (nt > 3) begin
            nt = 3;
            m_lost = 1'b1;
        end
        m_ticks = nt;
    endfunction

    task automatic check_outs();
        chk("time", bus.TIME, m_time);
        chk("busy", bus.BUSY, m_phase != 0);
        chk("done", bus.DONE, m_done);
        chk("err", bus.ERR, m_err);
        chk("tick_lost", bus.TICK_LOST, m_lost);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit v, input int code, input int val, input bit t);
        bus.OPER       = {TW'(val), OL'(code)};
        bus.OPER_VALID = v;
        bus.TICK       = t;
        #1;
        chk("oper_ready", bus.OPER_READY, mq.size() < DEPTH);
        @(posedge CLK);
        model_edge(v, code, val, t);
        #1;
        check_outs();
        @(negedge CLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    // Holds OPER_VALID until the word is accepted, bounded by a cycle budget.
    task automatic send(input int code, input int val);
        bit took = 1'b0;
        for (int i = 0; i < 20 && !took; i++) begin
            took = (mq.size() < DEPTH);
            step(1'b1, code, val, 1'b0);
        end
        chk("send_accepted", took, 1'b1);
    endtask

    task automatic hit_reset();
        RST_N = 1'b0;
        model_reset();
        #1;
        check_outs();
        chk("reset_ready", bus.OPER_READY, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int pushed;
        int t_before;
        int r, code, val;
        bit v, t;

        bus.OPER       = '0;
        bus.OPER_VALID = 1'b0;
        bus.TICK       = 1'b0;
        model_reset();
        #12;
        check_outs();
        chk("reset_ready", bus.OPER_READY, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;

        // ADD 3600: result and DONE exactly three edges after acceptance
        step(1'b1, 4, 3600, 1'b0);
        idle(2);
        chk("add_busy", bus.BUSY, 1'b1);
        idle(1);
        chk("add3600_time", bus.TIME, 3600);
        chk("add3600_done", bus.DONE, 1'b1);
        idle(1);

        // up to 86399, one tick wraps to 0, DEC 60 borrows to 86340
        send(4, 82799);
        idle(4);
        chk("t_86399", bus.TIME, 86399);
        step(1'b0, 0, 0, 1'b1);
        idle(3);
        chk("tick_wrap", bus.TIME, 0);
        send(2, 60);
        idle(4);
        chk("dec_borrow", bus.TIME, 86340);

        // queue fill under a continuous tick stream
        pushed = 0;
        for (int i = 0; i < 40; i++) begin
            v = (pushed < 4);
            if (v && mq.size() < DEPTH) pushed++;
            step(v, 4, 1, 1'b1);
        end
        idle(30);
        chk("fill_pushed", pushed, 4);

        // illegal opcode and out-of-range value leave TIME alone
        t_before = m_time;
        send(3, 5);
        send(4, 90000);
        send(4, 86400);
        idle(12);
        chk("err_time", bus.TIME, t_before);
        send(2, 86399);
        idle(4);

        // RESET op from 45000
        send(1, 0);
        idle(3);
        send(4, 45000);
        idle(4);
        chk("t_45000", bus.TIME, 45000);
        send(1, 0);
        idle(4);
        chk("reset_op", bus.TIME, 0);

        // reset asserted while ADD 60 is in EXEC
        send(4, 60);
        step(1'b1, 4, 7, 1'b0);
        chk("pre_rst_busy", bus.BUSY, 1'b1);
        bus.OPER_VALID = 1'b0;
        hit_reset();
        idle(8);
        chk("no_update_after_rst", bus.TIME, 0);

        // back-to-back operations keep their order
        send(4, 10);
        send(2, 3);
        idle(8);
        chk("b2b_order", bus.TIME, 7);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            code = (r < 1) ? 1 : (r < 4) ? 2 : (r < 8) ? 4 : $urandom_range(0, 7);
            val = ($urandom_range(0, 9) == 0) ? $urandom_range(DL, 262143)
                                               : $urandom_range(0, DL - 1);
            t = ($urandom_range(0, 3) == 0);
            step(v, code, val, t);
        end
        idle(40);
        chk("final_idle", bus.BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/time_oper_sched.md
# time_oper_sched

Sequencing controller for the clock's time-of-day register. Accepts operation words (`{value, opcode}`) from the button input driver, queues them, and arbitrates them against the 1 Hz seconds tick. Executes each as a two-step modulo-86400 update and drives the seconds-since-midnight value to the display path.

## Interface

**Parameters**
- `time_buff_size`, 18: value field width; also `TIME` width.
- `oper_l`, 3: opcode field width.
- `day_len`, 86400: modulus in seconds.
- `fifo_depth`, 4: operation queue depth, power of two.

**Ports**
- `CLK`, in, 1: single clock, all logic on the rising edge.
- `RST_N`, in, 1: asynchronous, active-low reset.
- `OPER`, in, `time_buff_size+oper_l`: operation word; `[time_buff_size+oper_l-1:oper_l]` is the value, `[oper_l-1:0]` is the opcode.
- `OPER_VALID`, in, 1: `OPER` is presented this cycle.
- `OPER_READY`, out, 1: queue can accept.
- `TICK`, in, 1: one-cycle pulse, once per second.
- `TIME`, out, `time_buff_size`: seconds since midnight, 0..`day_len`-1.
- `BUSY`, out, 1: FSM not in IDLE.
- `DONE`, out, 1: one-cycle pulse when `TIME` is updated.
- `ERR`, out, 1: one-cycle pulse when an illegal operation is discarded.
- `TICK_LOST`, out, 1: one-cycle pulse when a tick overflows the pending counter.

## Operation

**Opcodes**
- 1 = RESET: `TIME` ← 0.
- 2 = DEC: `TIME` ← (`TIME` − value) mod `day_len`.
- 4 = ADD: `TIME` ← (`TIME` + value) mod `day_len`.
- Any other opcode is popped and discarded with an `ERR` pulse.
- ADD or DEC with value ≥ `day_len` is popped and discarded with an `ERR` pulse.

**Queue**
- Accept when `OPER_VALID && OPER_READY`.
- `OPER_READY` = queue not full; it does not depend on a same-cycle pop.

**Tick pending counter**
- 2 bits, incremented by `TICK`, saturating at 3.
- `TICK` while the counter is at 3 pulses `TICK_LOST`.
- `TICK` in the same cycle as a tick grant leaves the counter unchanged.
- A tick executes as ADD 1.

**FSM**
- IDLE: select a source. If both queue and ticks are pending, grant the one not granted last (1-bit `last_grant`, reset value = tick). Otherwise grant whichever is pending, else stay in IDLE. On grant, latch the op, pop or decrement the source, go to EXEC.
- EXEC: form a 19-bit raw result. ADD: `TIME`+v. DEC: `TIME`−v, borrow kept in bit 18. RESET: 0. Illegal: flag it. Go to WRAP.
- WRAP: correct and commit.
  - ADD with raw ≥ `day_len`: subtract `day_len`.
  - DEC with borrow: add `day_len`.
  - Write `TIME` and pulse `DONE`. For an illegal op, leave `TIME` unchanged and pulse `ERR` instead of `DONE`.
  - Go to IDLE.

**Reset**
- `RST_N` low at any time, including mid-operation: the in-flight op is lost.
- Reset values:
  - `TIME`=0, `BUSY`=0, `DONE`=0, `ERR`=0, `TICK_LOST`=0.
  - Queue empty, so `OPER_READY`=1.
  - Tick counter 0, state IDLE.

## Timing

- Fixed 3 cycles per operation (IDLE grant, EXEC, WRAP); at most one operation per 3 cycles.
- An op accepted at edge N into an empty queue with the FSM in IDLE is granted at edge N+1. `TIME` and `DONE` are visible after edge N+3.
- A tick pulsed at edge N under the same conditions follows the same N+3 timing.
- `BUSY` is high in EXEC and WRAP.
- All outputs are registered except `OPER_READY`, which is combinational from the queue count.

## Configuration

- `TIME_SCHED_FIFO_EN` defined: queue depth is `fifo_depth`.
- `TIME_SCHED_FIFO_EN` undefined: a single holding register replaces the queue (depth 1).
  - `OPER_READY` is low from the accepting edge until the op is granted.
  - All other behaviour is identical.

## Structure

- Package `time_pkg`:
  - Opcode constants `OP_RESET`=1, `OP_DEC`=2, `OP_ADD`=4.
  - `DAY_LEN`=86400.
  - FSM state enum {IDLE, EXEC, WRAP}.
  - Grant-source typedef.
- Sub-module `oper_fifo`: synchronous FIFO with push/pop, full/empty and async active-low reset. It is instantiated only under `TIME_SCHED_FIFO_EN`.

## Test plan

- Reset, then ADD 3600 → `TIME`=3600 and `DONE` after 3 edges. `OPER_READY`=1 throughout.
- `TIME`=86399, one `TICK` → `TIME`=0 (wrap). From `TIME`=0, DEC 60 → `TIME`=86340 (borrow wrap).
- Fill the queue with 4 ADD 1 ops while `TICK` pulses continuously:
  - `OPER_READY` deasserts on full.
  - Grants alternate op/tick.
  - `TICK_LOST` pulses once the counter saturates.
  - Final `TIME` equals executed ops plus executed ticks.
- Opcode 3, then ADD value 90000 → two `ERR` pulses, no `DONE`, `TIME` unchanged.
- RESET op from `TIME`=45000 → `TIME`=0. Assert `RST_N` low during EXEC of ADD 60 → all outputs at reset values, queue empty, and no update after release.
- Build without `TIME_SCHED_FIFO_EN`: back-to-back `OPER_VALID` → second op stalls until the first is granted, and both execute in order.
